// File: rtl/dec_pfx_align_pkg.sv
// dec_pfx_align_pkg: shared constants and prefix test for the fetch/decode prefix aligner.
//   PFX_XE8    8'h8E  high byte of an XE prefix halfword
//   PFX_XEC    8'hCE  high byte of a CE-form prefix halfword
//   QDEPTH_DEF 4      default queue depth in halfwords
//   isPfx(h)          true when halfword h starts a two-halfword instruction
// Optional feature macro: DECPFX_CE_EN (CE-form prefixes also pair with their opcode).
package dec_pfx_align_pkg;
    localparam logic [7:0] PFX_XE8 = 8'h8E;
    localparam logic [7:0] PFX_XEC = 8'hCE;
    localparam int QDEPTH_DEF = 4;

    function automatic logic isPfx(input logic [15:0] h);
`ifdef DECPFX_CE_EN
        return (h[15:8] == PFX_XE8) || (h[15:8] == PFX_XEC);
`else
        return h[15:8] == PFX_XE8;
`endif
    endfunction
endpackage

// File: rtl/dec_pfx_hwqueue.sv
// dec_pfx_hwqueue: halfword circular queue with 2-wide push and 1/2-wide pop.
//   clock, reset (async active-low), flush (empties the queue)
//   pushCnt/pushData: halfwords to append (pushData[15:0] first)
//   popCnt: halfwords removed from the head this cycle
//   q0/q1: head halfword and the one after it; count: occupancy
module dec_pfx_hwqueue
    import dec_pfx_align_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [1:0]                pushCnt,
    input  logic [31:0]               pushData,
    input  logic [1:0]                popCnt,
    output logic [15:0]               q0,
    output logic [15:0]               q1,
    output logic [$clog2(QDEPTH):0]   count
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [QDEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;

    assign q0 = mem[rdPtr];
    assign q1 = mem[rdPtr + AW'(1)];

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            rdPtr <= rdPtr + AW'(popCnt);
            wrPtr <= wrPtr + AW'(pushCnt);
            count <= count + CW'(pushCnt) - CW'(popCnt);
        end
    end

    // Storage needs no reset: every read is qualified by count.
    always_ff @(posedge clock) begin
        if (!flush && pushCnt != 2'd0) mem[wrPtr] <= pushData[15:0];
        if (!flush && pushCnt == 2'd2) mem[wrPtr + AW'(1)] <= pushData[31:16];
    end
endmodule

// File: rtl/dec_pfx_align.sv
// dec_pfx_align: halfword queue and prefix aligner between fetch and decode.
//   clock, reset (async active-low), iFlush (discard everything buffered)
//   fetch side : ifWord, ifCnt, ifPc, ifValid -> ifReady
//   decode side: odWord {opcode,prefix|0000}, odPc, odLen, odIsXE, odValid <- odReady
// Optional feature macro: DECPFX_CE_EN (CExx heads are treated as prefixes).
module dec_pfx_align
    import dec_pfx_align_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF,
    parameter int PCW    = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           iFlush,
    input  logic [31:0]    ifWord,
    input  logic [1:0]     ifCnt,
    input  logic [PCW-1:0] ifPc,
    input  logic           ifValid,
    output logic           ifReady,
    output logic [31:0]    odWord,
    output logic [PCW-1:0] odPc,
    output logic [1:0]     odLen,
    output logic           odIsXE,
    output logic           odValid,
    input  logic           odReady
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [15:0]    q0;
    logic [15:0]    q1;
    logic [CW-1:0]  count;
    logic [1:0]     inCnt;
    logic [1:0]     popCnt;
    logic [PCW-1:0] headPc;
    logic           headPfx;

    // Registered count only, so there is no combinational path from odReady.
    assign ifReady = !iFlush && (count <= CW'(QDEPTH - 2));
    assign inCnt   = !(ifValid && ifReady) ? 2'd0 : ifCnt[1] ? 2'd2 : {1'b0, ifCnt[0]};
    assign headPfx = isPfx(q0);
    assign odValid = (count != '0) && (!headPfx || count >= CW'(2));
    assign odLen   = !odValid ? 2'd0 : headPfx ? 2'd2 : 2'd1;
    assign odIsXE  = odValid && headPfx;
    assign odWord  = !odValid ? 32'h0 : headPfx ? {q1, q0} : {q0, 16'h0000};
    assign odPc    = headPc;
    assign popCnt  = (odValid && odReady) ? odLen : 2'd0;

    dec_pfx_hwqueue #(.QDEPTH(QDEPTH)) uQueue (
        .clock    (clock),
        .reset    (reset),
        .flush    (iFlush),
        .pushCnt  (inCnt),
        .pushData (ifWord),
        .popCnt   (popCnt),
        .q0       (q0),
        .q1       (q1),
        .count    (count)
    );

    // A bundle landing in a queue that drains empty this cycle starts a new PC run.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) headPc <= '0;
        else if (inCnt != 2'd0 && count == CW'(popCnt)) headPc <= ifPc;
        else if (popCnt != 2'd0) headPc <= headPc + PCW'({popCnt, 1'b0});
    end
endmodule

// File: tb/tb_dec_pfx_align.sv
// tb_dec_pfx_align: directed self-checking bench for dec_pfx_align (QDEPTH=4, PCW=32).
module tb_dec_pfx_align;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iFlush = 1'b0;
    logic [31:0] ifWord = '0;
    logic [1:0]  ifCnt = '0;
    logic [31:0] ifPc = '0;
    logic        ifValid = 1'b0;
    logic        ifReady;
    logic [31:0] odWord;
    logic [31:0] odPc;
    logic [1:0]  odLen;
    logic        odIsXE;
    logic        odValid;
    logic        odReady = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    dec_pfx_align #(.QDEPTH(4), .PCW(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .iFlush  (iFlush),
        .ifWord  (ifWord),
        .ifCnt   (ifCnt),
        .ifPc    (ifPc),
        .ifValid (ifValid),
        .ifReady (ifReady),
        .odWord  (odWord),
        .odPc    (odPc),
        .odLen   (odLen),
        .odIsXE  (odIsXE),
        .odValid (odValid),
        .odReady (odReady)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkOd(input string tag, input logic [31:0] w, input logic [31:0] pc,
                         input logic [1:0] len, input logic xe);
        chk({tag, ".valid"}, 64'(odValid), 64'd1);
        chk({tag, ".word"}, 64'(odWord), 64'(w));
        chk({tag, ".pc"}, 64'(odPc), 64'(pc));
        chk({tag, ".len"}, 64'(odLen), 64'(len));
        chk({tag, ".xe"}, 64'(odIsXE), 64'(xe));
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [31:0] w, input logic [1:0] c, input logic [31:0] pc);
        ifWord = w;
        ifCnt = c;
        ifPc = pc;
        ifValid = 1'b1;
    endtask

    initial begin
        #3;
        chk("rst.valid", 64'(odValid), 64'd0);
        chk("rst.word", 64'(odWord), 64'd0);
        chk("rst.pc", 64'(odPc), 64'd0);
        chk("rst.len", 64'(odLen), 64'd0);
        chk("rst.xe", 64'(odIsXE), 64'd0);
        chk("rst.ifReady", 64'(ifReady), 64'd1);
        tick;
        reset = 1'b1;
        // 1: plain pair
        odReady = 1'b1;
        put(32'h6012_E105, 2'd2, 32'h1000);
        tick;
        ifValid = 1'b0;
        chkOd("t1a", 32'hE105_0000, 32'h1000, 2'd1, 1'b0);
        tick;
        chkOd("t1b", 32'h6012_0000, 32'h1002, 2'd1, 1'b0);
        tick;
        chk("t1.empty", 64'(odValid), 64'd0);
        // 2: prefixed, then a bundle continuing at 0x2004 with no bubble
        put(32'h3C12_8E04, 2'd2, 32'h2000);
        tick;
        chkOd("t2a", 32'h3C12_8E04, 32'h2000, 2'd2, 1'b1);
        put(32'h0002_0001, 2'd2, 32'h2004);
        tick;
        ifValid = 1'b0;
        chkOd("t2b", 32'h0001_0000, 32'h2004, 2'd1, 1'b0);
        tick;
        chkOd("t2c", 32'h0002_0000, 32'h2006, 2'd1, 1'b0);
        tick;
        chk("t2.empty", 64'(odValid), 64'd0);
        // 3: split prefix
        put(32'h0000_8E04, 2'd1, 32'h3000);
        tick;
        chk("t3.stall", 64'(odValid), 64'd0);
        put(32'h0000_3C12, 2'd1, 32'h3002);
        tick;
        ifValid = 1'b0;
        chkOd("t3", 32'h3C12_8E04, 32'h3000, 2'd2, 1'b1);
        tick;
        chk("t3.empty", 64'(odValid), 64'd0);
        // 4: backpressure
        odReady = 1'b0;
        put(32'h0002_0001, 2'd2, 32'h5000);
        tick;
        chkOd("t4a", 32'h0001_0000, 32'h5000, 2'd1, 1'b0);
        chk("t4a.ifReady", 64'(ifReady), 64'd1);
        put(32'h0004_0003, 2'd2, 32'h5004);
        tick;
        ifValid = 1'b0;
        chk("t4.full.ifReady", 64'(ifReady), 64'd0);
        chkOd("t4b", 32'h0001_0000, 32'h5000, 2'd1, 1'b0);
        tick;
        chkOd("t4c", 32'h0001_0000, 32'h5000, 2'd1, 1'b0);
        odReady = 1'b1;
        tick;
        chkOd("t4d", 32'h0002_0000, 32'h5002, 2'd1, 1'b0);
        chk("t4d.ifReady", 64'(ifReady), 64'd0);
        tick;
        chkOd("t4e", 32'h0003_0000, 32'h5004, 2'd1, 1'b0);
        chk("t4e.ifReady", 64'(ifReady), 64'd1);
        tick;
        chkOd("t4f", 32'h0004_0000, 32'h5006, 2'd1, 1'b0);
        tick;
        chk("t4.empty", 64'(odValid), 64'd0);
        // 5: flush with three halfwords buffered
        odReady = 1'b0;
        put(32'h0002_0001, 2'd2, 32'h6000);
        tick;
        put(32'h0000_0003, 2'd1, 32'h6004);
        tick;
        chk("t5.pre.valid", 64'(odValid), 64'd1);
        put(32'h0000_7777, 2'd1, 32'h7000);
        iFlush = 1'b1;
        #1;
        chk("t5.flush.ifReady", 64'(ifReady), 64'd0);
        tick;
        iFlush = 1'b0;
        chk("t5.flushed", 64'(odValid), 64'd0);
        odReady = 1'b1;
        put(32'h0000_0009, 2'd1, 32'h4000);
        tick;
        ifValid = 1'b0;
        chkOd("t5", 32'h0009_0000, 32'h4000, 2'd1, 1'b0);
        tick;
        chk("t5.dropped", 64'(odValid), 64'd0);
        // 6: CE-form word
        put(32'h2012_CE05, 2'd2, 32'h8000);
        tick;
        ifValid = 1'b0;
`ifdef DECPFX_CE_EN
        chkOd("t6", 32'h2012_CE05, 32'h8000, 2'd2, 1'b1);
`else
        chkOd("t6a", 32'hCE05_0000, 32'h8000, 2'd1, 1'b0);
        tick;
        chkOd("t6b", 32'h2012_0000, 32'h8002, 2'd1, 1'b0);
`endif
        tick;
        chk("t6.empty", 64'(odValid), 64'd0);
        // 7: async reset mid-drain
        odReady = 1'b0;
        put(32'h0002_0001, 2'd2, 32'h9000);
        tick;
        ifValid = 1'b0;
        odReady = 1'b1;
        chkOd("t7.pre", 32'h0001_0000, 32'h9000, 2'd1, 1'b0);
        tick;
        #1;
        reset = 1'b0;
        #1;
        chk("t7.valid", 64'(odValid), 64'd0);
        chk("t7.word", 64'(odWord), 64'd0);
        chk("t7.pc", 64'(odPc), 64'd0);
        chk("t7.len", 64'(odLen), 64'd0);
        chk("t7.xe", 64'(odIsXE), 64'd0);
        chk("t7.ifReady", 64'(ifReady), 64'd1);
        tick;
        reset = 1'b1;
        tick;
        chk("t7.after", 64'(odValid), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
